// File: rtl/aud_pkg.sv
// Shared types and sizing for the audio recorder: sample/address widths and the capture FSM states.
package aud_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned CNT_W    = 4;

    localparam logic [ADDR_W-1:0] ADDR_MAX_DEFAULT = 20'hFFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_SKIP,
        S_SHIFT,
        S_STORE,
        S_PAUSE
    } state_e;

endpackage

// File: rtl/i2s_rx_shifter.sv
// Serial-to-parallel shifter for one I2S word, MSB first, with a down-counting bit counter.
module i2s_rx_shifter
    import aud_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                sdata,
    output logic [SAMPLE_W-1:0] word,
    output logic                done
);

    logic [SAMPLE_W-1:0] sr_q;
    logic [CNT_W-1:0]    cnt_q;

    // word and done describe the edge in progress, so the caller can latch the
    // completed sample on the same edge that shifts in its last bit.
    assign word = {sr_q[SAMPLE_W-2:0], sdata};
    assign done = shift_en && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= CNT_W'(SAMPLE_W - 1);
        end else if (clear) begin
            sr_q  <= '0;
            cnt_q <= CNT_W'(SAMPLE_W - 1);
        end else if (load) begin
            cnt_q <= CNT_W'(SAMPLE_W - 1);
        end else if (shift_en) begin
            sr_q  <= word;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/aud_recorder.sv
// Left-channel I2S capture into SRAM: start/pause/stop control, frame alignment and address counting.
module aud_recorder
    import aud_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_MAX_DEFAULT
) (
    input  logic                i_bclk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic                i_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_we,
    output logic                o_full
);

    state_e              state;
    logic                active;
    logic                sh_clear;
    logic                sh_load;
    logic                sh_shift;
    logic [SAMPLE_W-1:0] sh_word;
    logic                sh_done;

    // States a pause request may interrupt; a write in S_STORE always completes.
    assign active = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH) ||
                    (state == S_SKIP) || (state == S_SHIFT);

    always_comb begin
        sh_clear = i_stop || (i_pause && active);
        sh_load  = !sh_clear && (state == S_SKIP);
        sh_shift = !sh_clear && (state == S_SHIFT);
    end

    i2s_rx_shifter u_shifter (
        .clk      (i_bclk),
        .rst_n    (i_rst_n),
        .load     (sh_load),
        .clear    (sh_clear),
        .shift_en (sh_shift),
        .sdata    (i_data),
        .word     (sh_word),
        .done     (sh_done)
    );

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_address <= '0;
            o_data    <= '0;
            o_we      <= 1'b0;
            o_full    <= 1'b0;
        end else begin
            o_we <= 1'b0;
            if (i_stop) begin
                state     <= S_IDLE;
                o_address <= '0;
                o_full    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_start && !i_pause && !o_full) state <= S_WAIT_LOW;
                    end
                    S_WAIT_LOW: begin
                        if (i_pause)     state <= S_PAUSE;
                        else if (!i_lrc) state <= S_WAIT_HIGH;
                    end
                    S_WAIT_HIGH: begin
                        if (i_pause)    state <= S_PAUSE;
                        else if (i_lrc) state <= S_SKIP;
                    end
                    S_SKIP: begin
                        state <= i_pause ? S_PAUSE : S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (i_pause) begin
                            state <= S_PAUSE;
                        end else if (sh_done) begin
                            o_data <= sh_word;
                            o_we   <= 1'b1;
                            state  <= S_STORE;
                        end
                    end
                    S_STORE: begin
                        if (o_address == ADDR_MAX) begin
                            o_full <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            o_address <= o_address + ADDR_W'(1);
                            state     <= i_pause ? S_PAUSE : S_WAIT_LOW;
                        end
                    end
                    S_PAUSE: begin
                        if (i_start && !i_pause) state <= S_WAIT_LOW;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: a default-depth instance plus a four-entry instance for the full case.
module tb_aud_recorder;

    logic        bclk = 1'b0;
    logic        rst_n;
    logic        lrc;
    logic        start;
    logic        pause;
    logic        stop;
    logic        sdata;
    logic [19:0] addr;
    logic [15:0] data;
    logic        we;
    logic        full;
    logic [19:0] s_addr;
    logic [15:0] s_data;
    logic        s_we;
    logic        s_full;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0;

    logic [19:0] w_addr[$];
    logic [15:0] w_data[$];
    int          w_cyc[$];
    logic [19:0] sw_addr[$];
    logic [15:0] sw_data[$];

    logic [15:0] words4[5];

    always #5 bclk = ~bclk;

    aud_recorder dut (
        .i_bclk    (bclk),
        .i_rst_n   (rst_n),
        .i_lrc     (lrc),
        .i_start   (start),
        .i_pause   (pause),
        .i_stop    (stop),
        .i_data    (sdata),
        .o_address (addr),
        .o_data    (data),
        .o_we      (we),
        .o_full    (full)
    );

    aud_recorder #(.ADDR_MAX(20'd3)) dut_small (
        .i_bclk    (bclk),
        .i_rst_n   (rst_n),
        .i_lrc     (lrc),
        .i_start   (start),
        .i_pause   (pause),
        .i_stop    (stop),
        .i_data    (sdata),
        .o_address (s_addr),
        .o_data    (s_data),
        .o_we      (s_we),
        .o_full    (s_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int i);
        return (w_addr.size() > i) ? {12'h0, w_addr[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (w_data.size() > i) ? {16'h0, w_data[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] swa(input int i);
        return (sw_addr.size() > i) ? {12'h0, sw_addr[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] swd(input int i);
        return (sw_data.size() > i) ? {16'h0, sw_data[i]} : 32'hxxxxxxxx;
    endfunction

    // Slot 0 is where lrc is first seen, slot 1 the delay slot, slots 2..17 carry bits 15..0.
    function automatic logic bitof(input logic [15:0] w, input int k);
        return (k >= 2 && k < 18) ? w[17-k] : 1'b1;
    endfunction

    task automatic clear_logs();
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        sw_addr.delete();
        sw_data.delete();
    endtask

    task automatic step(input logic l, input logic d);
        @(negedge bclk);
        lrc   = l;
        sdata = d;
        @(posedge bclk);
        #1;
        cyc++;
        if (we) begin
            w_addr.push_back(addr);
            w_data.push_back(data);
            w_cyc.push_back(cyc);
        end
        if (s_we) begin
            sw_addr.push_back(s_addr);
            sw_data.push_back(s_data);
        end
    endtask

    task automatic frame(input logic l, input logic [15:0] w, input int pause_k);
        for (int k = 0; k < 32; k++) begin
            if (k == pause_k) pause = 1'b1;
            step(l, bitof(w, k));
        end
    endtask

    task automatic right_frame();
        frame(1'b0, 16'hFFFF, -1);
    endtask

    task automatic start_pulse(input logic l);
        start = 1'b1;
        step(l, 1'b0);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        step(1'b0, 1'b0);
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        lrc   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        sdata = 1'b0;
        words4[0] = 16'hC001;
        words4[1] = 16'h5AA5;
        words4[2] = 16'h0F0F;
        words4[3] = 16'h8421;
        words4[4] = 16'h1357;
        #12;
        chk("reset_addr", {12'h0, addr}, 32'h0);
        chk("reset_data", {16'h0, data}, 32'h0);
        chk("reset_we", {31'h0, we}, 32'h0);
        chk("reset_full", {31'h0, full}, 32'h0);
        #10;
        rst_n = 1'b1;

        // Basic capture with latency check, then the next sample at address 1.
        clear_logs();
        start_pulse(1'b0);
        right_frame();
        c0 = cyc + 1;
        frame(1'b1, 16'hA5C3, -1);
        right_frame();
        frame(1'b1, 16'h1234, -1);
        chk("basic_count", w_addr.size(), 2);
        chk("basic_addr0", wa(0), 32'h0);
        chk("basic_data0", wd(0), 32'hA5C3);
        chk("basic_latency", (w_cyc.size() > 0) ? w_cyc[0] - c0 : -1, 17);
        chk("basic_addr1", wa(1), 32'h1);
        chk("basic_data1", wd(1), 32'h1234);
        right_frame();
        chk("hold_data", {16'h0, data}, 32'h1234);
        chk("hold_we", {31'h0, we}, 32'h0);
        stop_pulse();
        chk("stop_addr", {12'h0, addr}, 32'h0);

        // Right-channel word between two left words is never stored.
        clear_logs();
        start_pulse(1'b0);
        right_frame();
        frame(1'b1, 16'h0001, -1);
        frame(1'b0, 16'hFFFF, -1);
        frame(1'b1, 16'h8000, -1);
        right_frame();
        chk("right_count", w_addr.size(), 2);
        chk("right_data0", wd(0), 32'h0001);
        chk("right_addr0", wa(0), 32'h0);
        chk("right_data1", wd(1), 32'h8000);
        chk("right_addr1", wa(1), 32'h1);
        stop_pulse();

        // Pause at bit 8 of the fourth sample; resume stores the next frame at address 3.
        clear_logs();
        start_pulse(1'b0);
        right_frame();
        frame(1'b1, 16'h1111, -1);
        right_frame();
        frame(1'b1, 16'h2222, -1);
        right_frame();
        frame(1'b1, 16'h3333, -1);
        right_frame();
        frame(1'b1, 16'h4444, 9);
        right_frame();
        chk("pause_addr_held", {12'h0, addr}, 32'h3);
        chk("pause_count", w_addr.size(), 3);
        pause = 1'b0;
        start_pulse(1'b0);
        right_frame();
        frame(1'b1, 16'h5555, -1);
        chk("resume_count", w_addr.size(), 4);
        chk("resume_addr", wa(3), 32'h3);
        chk("resume_data", wd(3), 32'h5555);
        stop_pulse();

        // Four-entry instance fills after address 3 and ignores further frames and starts.
        clear_logs();
        start_pulse(1'b0);
        for (int i = 0; i < 5; i++) begin
            right_frame();
            frame(1'b1, words4[i], -1);
        end
        chk("full_count", sw_addr.size(), 4);
        chk("full_addr0", swa(0), 32'h0);
        chk("full_addr3", swa(3), 32'h3);
        chk("full_data3", swd(3), {16'h0, words4[3]});
        chk("full_flag", {31'h0, s_full}, 32'h1);
        chk("full_addr_held", {12'h0, s_addr}, 32'h3);
        chk("deep_count", w_addr.size(), 5);
        start_pulse(1'b0);
        right_frame();
        frame(1'b1, 16'h9999, -1);
        chk("full_start_ignored", sw_addr.size(), 4);
        stop_pulse();
        chk("full_cleared", {31'h0, s_full}, 32'h0);
        chk("full_stop_addr", {12'h0, s_addr}, 32'h0);

        // Start and stop together in idle: stop wins, nothing recorded.
        clear_logs();
        start = 1'b1;
        stop  = 1'b1;
        step(1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        right_frame();
        frame(1'b1, 16'h7E7E, -1);
        chk("startstop_count", w_addr.size(), 0);
        chk("startstop_addr", {12'h0, addr}, 32'h0);

        // Asynchronous reset in the middle of a shift, then realign to a fresh left frame.
        clear_logs();
        start_pulse(1'b0);
        right_frame();
        frame(1'b1, 16'h0F0F, -1);
        right_frame();
        for (int k = 0; k < 10; k++) step(1'b1, bitof(16'h7777, k));
        chk("pre_rst_addr", {12'h0, addr}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_addr", {12'h0, addr}, 32'h0);
        chk("rst_data", {16'h0, data}, 32'h0);
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_full", {31'h0, full}, 32'h0);
        step(1'b1, bitof(16'h7777, 10));
        step(1'b1, bitof(16'h7777, 11));
        rst_n = 1'b1;
        start = 1'b1;
        step(1'b1, bitof(16'h7777, 12));
        start = 1'b0;
        for (int k = 13; k < 32; k++) step(1'b1, bitof(16'h7777, k));
        right_frame();
        frame(1'b1, 16'h6006, -1);
        chk("rst_count", w_addr.size(), 2);
        chk("rst_first_addr", wa(1), 32'h0);
        chk("rst_first_data", wd(1), 32'h6006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
